rat_io_responder: RTL and testbench

//  Port-mapped I/O responder on the far side of the RAT CPU IN/OUT bus (port_id, out_port, io_strb, in_port, interrupt).

---
 rtl/rat_io_responder_pkg.sv | 32 +++
 rtl/rat_io_responder_if.sv | 14 +
 rtl/rat_io_responder_sync_edge.sv | 38 +++
 rtl/rat_io_responder.sv | 129 ++++++++++++
 tb/tb_rat_io_responder.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/rat_io_responder_pkg.sv
// Port map, register bit positions and timer control layout for the RAT I/O responder.
// Latency: n/a (definitions only); backpressure: n/a.
package rat_io_pkg;

  localparam logic [7:0] PORT_SW         = 8'h00;
  localparam logic [7:0] PORT_LED        = 8'h40;
  localparam logic [7:0] PORT_TMR_CTRL   = 8'h80;
  localparam logic [7:0] PORT_TMR_RELOAD = 8'h81;
  localparam logic [7:0] PORT_TMR_COUNT  = 8'h82;
  localparam logic [7:0] PORT_IRQ_STATUS = 8'h83;
  localparam logic [7:0] PORT_IRQ_MASK   = 8'h84;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_AUTO_BIT = 1;
  localparam int IRQ_TMR_BIT   = 0;
  localparam int IRQ_EXT_BIT   = 1;

  typedef struct packed {
    logic en;
    logic auto;
  } tmr_ctrl_t;

  // Struct field order differs from the register bit order, so map explicitly.
  function automatic logic [7:0] ctrl_to_byte(input tmr_ctrl_t c);
    logic [7:0] b;
    b = 8'h00;
    b[CTRL_EN_BIT]   = c.en;
    b[CTRL_AUTO_BIT] = c.auto;
    return b;
  endfunction

endpackage

// File: rtl/rat_io_responder_if.sv
// RAT CPU IN/OUT bus: CPU drives address, data and strobe; responder returns read data and IRQ.
// Latency: in_port combinational, interrupt registered; backpressure: none.
interface rat_io_responder_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       io_strb;
  logic [7:0] in_port;
  logic       interrupt;

  modport master (output port_id, output out_port, output io_strb,
                  input in_port, input interrupt);
  modport slave  (input port_id, input out_port, input io_strb,
                  output in_port, output interrupt);
endinterface

// File: rtl/rat_io_responder_sync_edge.sv
// STAGES-flop synchronizer bank with a registered rising-edge pulse aligned to the synced output.
// Latency: q follows d after STAGES clk, rise coincides with q's first high cycle; backpressure: none.
module rat_sync_edge #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] stage [STAGES];
  logic [WIDTH-1:0] nxt_last;

  generate
    if (STAGES == 1) begin : g_one
      assign nxt_last = d;
    end else begin : g_multi
      assign nxt_last = stage[STAGES-2];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
      rise <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      rise <= nxt_last & ~stage[STAGES-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/rat_io_responder.sv
// Port-mapped LED/timer/IRQ register block behind the RAT CPU IN/OUT bus.
// Latency: writes visible next clk, reads combinational, IRQ one clk after status; backpressure: none.
module rat_io_responder
  import rat_io_pkg::*;
#(
  parameter int PRESCALE_W  = 16,
  parameter int PRESCALE    = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rat_io_responder_if.slave    bus,
  input  logic [7:0]           switches_in,
  input  logic                 ext_event,
  output logic [7:0]           leds_out
);

  localparam logic [PRESCALE_W-1:0] PRESC_MAX = PRESCALE_W'(PRESCALE - 1);

  logic [7:0]            sw_sync;
  logic [7:0]            sw_rise_unused;
  logic                  ext_sync_unused;
  logic                  ext_rise;

  logic [7:0]            led;
  tmr_ctrl_t             ctrl;
  logic [7:0]            reload;
  logic [7:0]            count;
  logic [1:0]            status;
  logic [1:0]            mask;
  logic [PRESCALE_W-1:0] presc;
  logic                  irq;

  logic                  wr_led, wr_ctrl, wr_reload, wr_status, wr_mask;
  logic                  ctrl_start, tick, expire;
  logic [1:0]            hw_set, w1c;

  rat_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(8)) u_sw_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (switches_in),
    .q     (sw_sync),
    .rise  (sw_rise_unused)
  );

  rat_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_ext_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ext_event),
    .q     (ext_sync_unused),
    .rise  (ext_rise)
  );

  assign wr_led    = bus.io_strb && (bus.port_id == PORT_LED);
  assign wr_ctrl   = bus.io_strb && (bus.port_id == PORT_TMR_CTRL);
  assign wr_reload = bus.io_strb && (bus.port_id == PORT_TMR_RELOAD);
  assign wr_status = bus.io_strb && (bus.port_id == PORT_IRQ_STATUS);
  assign wr_mask   = bus.io_strb && (bus.port_id == PORT_IRQ_MASK);

  // Only an EN 0->1 transition restarts; rewriting EN=1 while running leaves the count alone.
  assign ctrl_start = wr_ctrl && bus.out_port[CTRL_EN_BIT] && !ctrl.en;
  assign tick       = ctrl.en && (presc == PRESC_MAX);
  assign expire     = tick && (count == 8'h00);
  assign w1c        = wr_status ? bus.out_port[1:0] : 2'b00;

  always_comb begin
    hw_set              = 2'b00;
    hw_set[IRQ_TMR_BIT] = expire;
    hw_set[IRQ_EXT_BIT] = ext_rise;
  end

  always_comb begin
    bus.in_port = 8'h00;
    case (bus.port_id)
      PORT_SW:         bus.in_port = sw_sync;
      PORT_LED:        bus.in_port = led;
      PORT_TMR_CTRL:   bus.in_port = ctrl_to_byte(ctrl);
      PORT_TMR_RELOAD: bus.in_port = reload;
      PORT_TMR_COUNT:  bus.in_port = count;
      PORT_IRQ_STATUS: bus.in_port = {6'b0, status};
      PORT_IRQ_MASK:   bus.in_port = {6'b0, mask};
      default:         bus.in_port = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led    <= 8'h00;
      ctrl   <= '0;
      reload <= 8'h00;
      count  <= 8'h00;
      status <= 2'b00;
      mask   <= 2'b00;
      presc  <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr_led)    led    <= bus.out_port;
      if (wr_reload) reload <= bus.out_port;
      if (wr_mask)   mask   <= bus.out_port[1:0];

      // A CPU write to TMR_CTRL overrides the one-shot auto-clear of EN.
      if (wr_ctrl) begin
        ctrl.en   <= bus.out_port[CTRL_EN_BIT];
        ctrl.auto <= bus.out_port[CTRL_AUTO_BIT];
      end else if (expire && !ctrl.auto) begin
        ctrl.en <= 1'b0;
      end

      if (ctrl_start) begin
        count <= reload;
        presc <= '0;
      end else if (tick) begin
        presc <= '0;
        if (count != 8'h00)  count <= count - 8'd1;
        else if (ctrl.auto)  count <= reload;
      end else if (ctrl.en) begin
        presc <= presc + PRESCALE_W'(1);
      end

      // Hardware set is OR-ed in after the clear so it wins a same-cycle collision.
      status <= (status & ~w1c) | hw_set;
      irq    <= |(status & mask);
    end
  end

  assign leds_out      = led;
  assign bus.interrupt = irq;

endmodule

// File: tb/tb_rat_io_responder.sv
// Directed table-driven bench for rat_io_responder with hand sequences for timer, edge and reset corners.
module tb_rat_io_responder;

  logic       clk;
  logic       rst_n;
  logic [7:0] switches_in;
  logic       ext_event;
  logic [7:0] leds_out;

  int checks = 0;
  int errors = 0;

  rat_io_responder_if bus();

  rat_io_responder #(.PRESCALE_W(16), .PRESCALE(4), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .switches_in (switches_in),
    .ext_event   (ext_event),
    .leds_out    (leds_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] port;
    logic [7:0] data;
    logic [7:0] exp_rd;
    logic [7:0] exp_led;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_rd(input string nm, input logic [7:0] p, input logic [7:0] exp);
    bus.port_id = p;
    #1;
    check(nm, bus.in_port, exp);
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    @(negedge clk);
    bus.port_id  = p;
    bus.out_port = d;
    bus.io_strb  = 1'b1;
    @(negedge clk);
    bus.io_strb  = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 8'h40, 8'h00, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 8'h80, 8'h00, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 8'h81, 8'h00, 8'h00, 8'h00};
    tbl[4]  = '{1'b0, 8'h82, 8'h00, 8'h00, 8'h00};
    tbl[5]  = '{1'b0, 8'h83, 8'h00, 8'h00, 8'h00};
    tbl[6]  = '{1'b0, 8'h84, 8'h00, 8'h00, 8'h00};
    tbl[7]  = '{1'b0, 8'h55, 8'h00, 8'h00, 8'h00};
    tbl[8]  = '{1'b1, 8'h40, 8'hA5, 8'hA5, 8'hA5};
    tbl[9]  = '{1'b1, 8'h55, 8'hFF, 8'h00, 8'hA5};
    tbl[10] = '{1'b1, 8'h82, 8'h77, 8'h00, 8'hA5};
    tbl[11] = '{1'b1, 8'h00, 8'h33, 8'h00, 8'hA5};
    tbl[12] = '{1'b1, 8'h84, 8'hFF, 8'h03, 8'hA5};
    tbl[13] = '{1'b1, 8'h84, 8'h01, 8'h01, 8'hA5};
    tbl[14] = '{1'b1, 8'h81, 8'h02, 8'h02, 8'hA5};
    tbl[15] = '{1'b1, 8'h83, 8'hFF, 8'h00, 8'hA5};

    rst_n        = 1'b0;
    switches_in  = 8'h00;
    ext_event    = 1'b0;
    bus.port_id  = 8'h00;
    bus.out_port = 8'h00;
    bus.io_strb  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("rst_irq", {7'b0, bus.interrupt}, 8'h00);
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) wr(tbl[i].port, tbl[i].data);
      else           @(negedge clk);
      chk_rd($sformatf("tbl%0d_rd", i), tbl[i].port, tbl[i].exp_rd);
      check($sformatf("tbl%0d_led", i), leds_out, tbl[i].exp_led);
    end

    // Bus values present without io_strb must not write.
    @(negedge clk);
    bus.port_id  = 8'h40;
    bus.out_port = 8'h5A;
    @(negedge clk);
    check("nostrb_led", leds_out, 8'hA5);
    chk_rd("nostrb_rd", 8'h40, 8'hA5);

    // Switches appear on the SW port after exactly two sync flops.
    @(negedge clk);
    switches_in = 8'h3C;
    @(negedge clk);
    chk_rd("sw_1clk", 8'h00, 8'h00);
    @(negedge clk);
    chk_rd("sw_2clk", 8'h00, 8'h3C);

    // Auto-reload timer: PRESCALE=4, RELOAD=2 -> expiry 12 clk after the start write.
    wr(8'h80, 8'h03);
    repeat (3) @(negedge clk);
    chk_rd("tmr_cnt_e3", 8'h82, 8'h02);
    @(negedge clk);
    chk_rd("tmr_cnt_e4", 8'h82, 8'h01);
    repeat (7) @(negedge clk);
    chk_rd("tmr_cnt_e11", 8'h82, 8'h00);
    chk_rd("tmr_st_e11", 8'h83, 8'h00);
    @(negedge clk);
    chk_rd("tmr_st_e12", 8'h83, 8'h01);
    chk_rd("tmr_cnt_e12", 8'h82, 8'h02);
    check("tmr_irq_e12", {7'b0, bus.interrupt}, 8'h00);
    @(negedge clk);
    check("tmr_irq_e13", {7'b0, bus.interrupt}, 8'h01);
    wr(8'h83, 8'h01);
    chk_rd("w1c_st", 8'h83, 8'h00);
    check("w1c_irq_still", {7'b0, bus.interrupt}, 8'h01);
    @(negedge clk);
    check("w1c_irq_drop", {7'b0, bus.interrupt}, 8'h00);
    repeat (7) @(negedge clk);
    chk_rd("tmr2_st_e23", 8'h83, 8'h00);
    @(negedge clk);
    chk_rd("tmr2_st_e24", 8'h83, 8'h01);
    wr(8'h80, 8'h00);
    wr(8'h83, 8'h03);

    // One-shot with RELOAD=0: expires on the first tick and clears EN.
    wr(8'h81, 8'h00);
    wr(8'h80, 8'h01);
    chk_rd("os_ctrl_start", 8'h80, 8'h01);
    repeat (3) @(negedge clk);
    chk_rd("os_st_pre", 8'h83, 8'h00);
    @(negedge clk);
    chk_rd("os_st", 8'h83, 8'h01);
    chk_rd("os_ctrl", 8'h80, 8'h00);
    chk_rd("os_cnt", 8'h82, 8'h00);
    repeat (8) @(negedge clk);
    chk_rd("os_ctrl_hold", 8'h80, 8'h00);
    chk_rd("os_cnt_hold", 8'h82, 8'h00);

    // External event: 3-clk pulse sets STATUS.EXT SYNC_STAGES+1 clk later.
    wr(8'h83, 8'h03);
    ext_event = 1'b1;
    repeat (2) @(negedge clk);
    chk_rd("ext_st_2clk", 8'h83, 8'h00);
    @(negedge clk);
    chk_rd("ext_st_3clk", 8'h83, 8'h02);
    ext_event = 1'b0;
    repeat (3) @(negedge clk);

    // Edge-set collides with W1C of the same bit: set wins.
    ext_event = 1'b1;
    repeat (2) @(negedge clk);
    bus.port_id  = 8'h83;
    bus.out_port = 8'h02;
    bus.io_strb  = 1'b1;
    @(negedge clk);
    bus.io_strb  = 1'b0;
    chk_rd("ext_setwins", 8'h83, 8'h02);
    wr(8'h83, 8'h02);
    chk_rd("ext_w1c_alone", 8'h83, 8'h00);
    ext_event = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-count with LEDs lit and IRQ high.
    wr(8'h84, 8'h02);
    wr(8'h40, 8'hFF);
    wr(8'h81, 8'h05);
    wr(8'h80, 8'h03);
    ext_event = 1'b1;
    repeat (4) @(negedge clk);
    check("pre_rst_irq", {7'b0, bus.interrupt}, 8'h01);
    check("pre_rst_led", leds_out, 8'hFF);
    #2;
    rst_n     = 1'b0;
    ext_event = 1'b0;
    #1;
    check("arst_led", leds_out, 8'h00);
    check("arst_irq", {7'b0, bus.interrupt}, 8'h00);
    chk_rd("arst_rd_led", 8'h40, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk_rd("post_rst_cnt", 8'h82, 8'h00);
    chk_rd("post_rst_ctrl", 8'h80, 8'h00);
    chk_rd("post_rst_st", 8'h83, 8'h00);
    wr(8'h80, 8'h01);
    repeat (4) @(negedge clk);
    chk_rd("post_rst_restart", 8'h83, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
